// File: rtl/istft_overlap_add_if.sv
// Sample-stream bundle for the ISTFT overlap-add stage: IFFT samples in, time-domain samples out.
// master drives the input side (IFFT source); slave is the overlap-add block itself.
interface istft_overlap_add_if #(
    parameter int IW = 18,
    parameter int OW = 16
) ();
    logic                 i_ce;
    logic                 i_sync;
    logic signed [IW-1:0] i_sample;
    logic signed [OW-1:0] o_sample;
    logic                 o_ce;
    logic                 o_frame;
    logic                 o_err;

    modport master (
        output i_ce, i_sync, i_sample,
        input  o_sample, o_ce, o_frame, o_err
    );

    modport slave (
        input  i_ce, i_sync, i_sample,
        output o_sample, o_ce, o_frame, o_err
    );
endinterface

// File: rtl/istft_overlap_add.sv
// 50%-overlap add of real IFFT frames into a continuous sample stream (one output per head sample).
// Optional macro ISTFT_OLA_HALVE_EN: halve the overlap sum (round-half-up) before output formatting.
module istft_overlap_add #(
    parameter int IW       = 18,
    parameter int OW       = 16,
    parameter int FFT_SIZE = 256,
    parameter int HOP_SIZE = 128
) (
    input logic               i_clk,
    input logic               i_reset_n,
    istft_overlap_add_if.slave ifc
);
    localparam int NW = $clog2(FFT_SIZE);
    localparam int HW = NW - 1;
    localparam int SW = IW + 1;

    if (HOP_SIZE != FFT_SIZE / 2) begin : g_badHop
        $error("istft_overlap_add: HOP_SIZE must equal FFT_SIZE/2");
    end
    if (FFT_SIZE < 4 || (FFT_SIZE & (FFT_SIZE - 1)) != 0) begin : g_badFft
        $error("istft_overlap_add: FFT_SIZE must be a power of two >= 4");
    end

    typedef enum logic [1:0] {IDLE, HEAD, TAIL, WAIT} state_t;

    state_t               r_state;
    state_t               w_stateNext;
    logic [NW-1:0]        r_index;
    logic [NW-1:0]        w_indexNext;
    logic signed [IW-1:0] r_tail [HOP_SIZE];

    logic                 w_doHead;
    logic                 w_doTail;
    logic                 w_err;
    logic [HW-1:0]        w_headIdx;

    logic signed [SW-1:0] w_sum;
    logic signed [SW-1:0] w_pre;
    logic signed [OW-1:0] w_fmt;

    logic signed [OW-1:0] r_oSample;
    logic                 r_oCe;
    logic                 r_oFrame;
    logic                 r_oErr;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= IDLE;
            r_index <= '0;
        end else begin
            r_state <= w_stateNext;
            r_index <= w_indexNext;
        end
    end

    // Any synced sample restarts a frame at n=0; the sync is an error only when it lands mid-frame.
    always_comb begin
        w_stateNext = r_state;
        w_indexNext = r_index;
        w_doHead    = 1'b0;
        w_doTail    = 1'b0;
        w_err       = 1'b0;
        w_headIdx   = r_index[HW-1:0];
        if (ifc.i_ce) begin
            case (r_state)
                IDLE, WAIT: begin
                    if (ifc.i_sync) begin
                        w_doHead    = 1'b1;
                        w_headIdx   = '0;
                        w_stateNext = HEAD;
                        w_indexNext = NW'(1);
                    end else if (r_state == WAIT) begin
                        w_err       = 1'b1;
                        w_stateNext = IDLE;
                        w_indexNext = '0;
                    end
                end
                HEAD, TAIL: begin
                    if (ifc.i_sync) begin
                        w_err       = 1'b1;
                        w_doHead    = 1'b1;
                        w_headIdx   = '0;
                        w_stateNext = HEAD;
                        w_indexNext = NW'(1);
                    end else if (r_state == HEAD) begin
                        w_doHead    = 1'b1;
                        w_indexNext = r_index + NW'(1);
                        if (r_index == NW'(HOP_SIZE - 1)) begin
                            w_stateNext = TAIL;
                        end
                    end else begin
                        w_doTail    = 1'b1;
                        w_indexNext = r_index + NW'(1);
                        if (r_index == NW'(FFT_SIZE - 1)) begin
                            w_stateNext = WAIT;
                        end
                    end
                end
                default: begin
                    w_stateNext = IDLE;
                    w_indexNext = '0;
                end
            endcase
        end
    end

`ifdef ISTFT_OLA_HALVE_EN
    logic signed [SW:0] w_halfSum;
`endif

    always_comb begin
        w_sum = SW'(r_tail[w_headIdx]) + SW'(ifc.i_sample);
`ifdef ISTFT_OLA_HALVE_EN
        w_halfSum = (SW + 1)'(w_sum) + (SW + 1)'(1);
        w_pre     = w_halfSum[SW:1];
`else
        w_pre     = w_sum;
`endif
    end

    if (OW >= SW) begin : g_ext
        assign w_fmt = OW'(w_pre);
    end else begin : g_sat
        // Shift keeps full-scale input mapped to full-scale output; half-LSB bias gives round-half-up.
        localparam int                 S    = IW - OW;
        localparam logic signed [SW:0] RND  = (SW + 1)'((2 ** S) / 2);
        localparam logic signed [SW:0] MAXV = (SW + 1)'(2 ** (OW - 1) - 1);
        localparam logic signed [SW:0] MINV = (SW + 1)'(-(2 ** (OW - 1)));
        logic signed [SW:0] w_shift;

        always_comb begin
            w_shift = ((SW + 1)'(w_pre) + RND) >>> S;
            if (w_shift > MAXV) begin
                w_fmt = MAXV[OW-1:0];
            end else if (w_shift < MINV) begin
                w_fmt = MINV[OW-1:0];
            end else begin
                w_fmt = w_shift[OW-1:0];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_oSample <= '0;
            r_oCe     <= 1'b0;
            r_oFrame  <= 1'b0;
            r_oErr    <= 1'b0;
            for (int i = 0; i < HOP_SIZE; i++) begin
                r_tail[i] <= '0;
            end
        end else begin
            r_oCe    <= w_doHead;
            r_oFrame <= w_doHead && (w_headIdx == '0);
            r_oErr   <= w_err;
            if (w_doHead) begin
                r_oSample <= w_fmt;
            end
            if (w_doTail) begin
                r_tail[r_index[HW-1:0]] <= ifc.i_sample;
            end
        end
    end

    assign ifc.o_sample = r_oSample;
    assign ifc.o_ce     = r_oCe;
    assign ifc.o_frame  = r_oFrame;
    assign ifc.o_err    = r_oErr;
endmodule

// File: tb/tb_istft_overlap_add.sv
// Self-checking bench for istft_overlap_add: two instances (OW=18 and OW=16) share one stimulus stream
// and are compared every cycle against a frame-level overlap-add model.
module tb_istft_overlap_add;
    localparam int IW  = 18;
    localparam int FFT = 8;
    localparam int HOP = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    istft_overlap_add_if #(.IW(IW), .OW(18)) ifcA ();
    istft_overlap_add_if #(.IW(IW), .OW(16)) ifcB ();

    istft_overlap_add #(.IW(IW), .OW(18), .FFT_SIZE(FFT), .HOP_SIZE(HOP)) dutA (
        .i_clk(clk), .i_reset_n(rst_n), .ifc(ifcA)
    );
    istft_overlap_add #(.IW(IW), .OW(16), .FFT_SIZE(FFT), .HOP_SIZE(HOP)) dutB (
        .i_clk(clk), .i_reset_n(rst_n), .ifc(ifcB)
    );

    int checks = 0;
    int errors = 0;

    // Model: position of the next expected frame sample (-1 = hunting for sync, FFT = frame complete).
    int mPos;
    int mTail [HOP];

    bit expNextCe, expNextFrame, expNextErr, expNextRst;
    int expNextA, expNextB;

    int obsA [$];
    int obsB [$];
    int errSeen   = 0;
    int frameSeen = 0;

    function automatic int clampTo(int v, int bits);
        int hi = (1 << (bits - 1)) - 1;
        int lo = -(1 << (bits - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic int preShift(int s);
`ifdef ISTFT_OLA_HALVE_EN
        return (s + 1) >>> 1;
`else
        return s;
`endif
    endfunction

    task automatic checkOutput(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelEmit(int n, int x);
        int s;
        s            = preShift(mTail[n] + x);
        expNextCe    = 1'b1;
        expNextFrame = (n == 0);
        expNextA     = clampTo(s, 18);
        expNextB     = clampTo((s + 2) >>> 2, 16);
    endtask

    task automatic modelStep(bit ce, bit sync, int x);
        expNextCe    = 1'b0;
        expNextFrame = 1'b0;
        expNextErr   = 1'b0;
        expNextRst   = 1'b0;
        if (!ce) return;
        if (sync) begin
            expNextErr = (mPos >= 1 && mPos <= FFT - 1);
            modelEmit(0, x);
            mPos = 1;
        end else if (mPos == FFT) begin
            expNextErr = 1'b1;
            mPos       = -1;
        end else if (mPos >= 0 && mPos < HOP) begin
            modelEmit(mPos, x);
            mPos++;
        end else if (mPos >= HOP) begin
            mTail[mPos - HOP] = x;
            mPos++;
        end
    endtask

    task automatic applyStimulus(bit ce, bit sync, logic [IW-1:0] x);
        @(negedge clk);
        ifcA.i_ce     = ce;
        ifcB.i_ce     = ce;
        ifcA.i_sync   = sync;
        ifcB.i_sync   = sync;
        ifcA.i_sample = x;
        ifcB.i_sample = x;
        modelStep(ce, sync, int'($signed(x)));
    endtask

    task automatic modelReset();
        mPos = -1;
        for (int i = 0; i < HOP; i++) mTail[i] = 0;
        expNextCe    = 1'b0;
        expNextFrame = 1'b0;
        expNextErr   = 1'b0;
        expNextA     = 0;
        expNextB     = 0;
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst_n         = 1'b0;
        ifcA.i_ce     = 1'b0;
        ifcB.i_ce     = 1'b0;
        ifcA.i_sync   = 1'b0;
        ifcB.i_sync   = 1'b0;
        ifcA.i_sample = '0;
        ifcB.i_sample = '0;
        modelReset();
        expNextRst = 1'b1;
        repeat (2) @(negedge clk);
        rst_n      = 1'b1;
        expNextRst = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) applyStimulus(1'b0, 1'b0, '0);
    endtask

    task automatic sendSeq(int start, int step, int count, bit syncFirst);
        for (int i = 0; i < count; i++) begin
            applyStimulus(1'b1, syncFirst && (i == 0), IW'(start + i * step));
        end
    endtask

    // Compares the last e.size() observed samples against literal expectations.
    task automatic checkTail(string name, input int q[$], input int e[$], int expCount);
        checkOutput($sformatf("%s_count", name), q.size(), expCount);
        for (int i = 0; i < e.size(); i++) begin
            if (q.size() >= e.size()) begin
                checkOutput($sformatf("%s_%0d", name, i), q[q.size() - e.size() + i], e[i]);
            end
        end
    endtask

    always begin : compareProc
        bit cCe, cFrame, cErr, cRst;
        int cA, cB;
        @(posedge clk);
        cCe    = expNextCe;
        cFrame = expNextFrame;
        cErr   = expNextErr;
        cRst   = expNextRst;
        cA     = cRst ? 0 : expNextA;
        cB     = cRst ? 0 : expNextB;
        #2;
        checkOutput("ceA",    int'(ifcA.o_ce),    int'(cCe));
        checkOutput("frameA", int'(ifcA.o_frame), int'(cFrame));
        checkOutput("errA",   int'(ifcA.o_err),   int'(cErr));
        checkOutput("ceB",    int'(ifcB.o_ce),    int'(cCe));
        checkOutput("frameB", int'(ifcB.o_frame), int'(cFrame));
        checkOutput("errB",   int'(ifcB.o_err),   int'(cErr));
        if (cCe || cRst) begin
            checkOutput("sampleA", int'(ifcA.o_sample), cA);
            checkOutput("sampleB", int'(ifcB.o_sample), cB);
        end
        if (ifcA.o_ce)    obsA.push_back(int'(ifcA.o_sample));
        if (ifcB.o_ce)    obsB.push_back(int'(ifcB.o_sample));
        if (ifcA.o_err)   errSeen++;
        if (ifcA.o_frame) frameSeen++;
    end

    initial begin
        int expQ [$];
        int e0, n0, since;
        bit s;
        logic [IW-1:0] x;

        ifcA.i_ce = 1'b0; ifcB.i_ce = 1'b0;
        ifcA.i_sync = 1'b0; ifcB.i_sync = 1'b0;
        ifcA.i_sample = '0; ifcB.i_sample = '0;
        modelReset();
        expNextRst = 1'b1;

        #7;
        checkOutput("rstSampleA", int'(ifcA.o_sample), 0);
        checkOutput("rstCeA",     int'(ifcA.o_ce),     0);
        checkOutput("rstFrameA",  int'(ifcA.o_frame),  0);
        checkOutput("rstErrA",    int'(ifcA.o_err),    0);
        checkOutput("rstSampleB", int'(ifcB.o_sample), 0);
        repeat (2) @(negedge clk);
        rst_n      = 1'b1;
        expNextRst = 1'b0;

        // Three back-to-back frames from reset
        sendSeq(1, 1, 8, 1'b1);
        sendSeq(10, 10, 8, 1'b1);
        sendSeq(0, 0, 8, 1'b1);
        idle(2);
`ifdef ISTFT_OLA_HALVE_EN
        expQ = '{1, 1, 2, 2, 8, 13, 19, 24, 25, 30, 35, 40};
`else
        expQ = '{1, 2, 3, 4, 15, 26, 37, 48, 50, 60, 70, 80};
`endif
        checkTail("threeFrames", obsA, expQ, 12);
        checkOutput("threeFramesFrameCount", frameSeen, 3);

        // Saturation: two full-scale frames
        applyReset();
        obsA.delete();
        obsB.delete();
        sendSeq(131071, 0, 8, 1'b1);
        sendSeq(131071, 0, 8, 1'b1);
        idle(2);
        expQ = '{32767, 32767, 32767, 32767};
        checkTail("satB", obsB, expQ, 8);
        expQ = '{131071, 131071, 131071, 131071};
        checkTail("satA", obsA, expQ, 8);

        // Early sync after three samples of a frame
        applyReset();
        obsA.delete();
        sendSeq(1, 1, 8, 1'b1);
        sendSeq(100, 100, 3, 1'b1);
        e0 = errSeen;
        applyStimulus(1'b1, 1'b1, IW'(9));
        idle(2);
`ifdef ISTFT_OLA_HALVE_EN
        expQ = '{7};
`else
        expQ = '{14};
`endif
        checkTail("earlySync", obsA, expQ, 8);
        checkOutput("earlySyncErrCount", errSeen - e0, 1);

        // Finish the restarted frame, then omit the sync
        sendSeq(10, 10, 7, 1'b0);
        idle(2);
        n0 = obsA.size();
        e0 = errSeen;
        sendSeq(99, 1, 4, 1'b0);
        idle(2);
        checkOutput("missingSyncNoOutput", obsA.size(), n0);
        checkOutput("missingSyncErrCount", errSeen - e0, 1);
        sendSeq(1, 1, 8, 1'b1);
        idle(2);
        checkOutput("resyncOutputs", obsA.size(), n0 + 4);

        // Reset during the tail half clears the stored tail
        applyReset();
        sendSeq(7, 1, 6, 1'b1);
        applyReset();
        obsA.delete();
        sendSeq(5, 1, 8, 1'b1);
        idle(2);
`ifdef ISTFT_OLA_HALVE_EN
        expQ = '{3, 3, 4, 4};
`else
        expQ = '{5, 6, 7, 8};
`endif
        checkTail("resetMidTail", obsA, expQ, 4);

        // Randomized traffic: gaps, occasional early/missing syncs, rare resets
        since = FFT;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 599) == 0) begin
                applyReset();
                since = FFT;
            end else if ($urandom_range(0, 3) == 0) begin
                applyStimulus(1'b0, 1'b0, '0);
            end else begin
                s = (since >= FFT && $urandom_range(0, 9) != 0) || ($urandom_range(0, 49) == 0);
                since = s ? 1 : since + 1;
                if ($urandom_range(0, 2) == 0) begin
                    x = IW'(int'($urandom_range(0, 512)) - 256);
                end else begin
                    x = IW'($urandom);
                end
                applyStimulus(1'b1, s, x);
            end
        end
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
